// File: rtl/binary_to_ascii_decimal_pkg.sv
// binary_to_ascii_decimal_pkg: shared sizes, ASCII codes and FSM states for the decimal display path
package binary_to_ascii_decimal_pkg;
    localparam int DEF_NUM_DIGITS = 10;
    localparam int DEF_BITS_PER_ASCII_DIGIT = 8;
    localparam int DEF_BIN_BITS = 40;
    localparam int DEF_BUF_BITS = DEF_NUM_DIGITS * DEF_BITS_PER_ASCII_DIGIT;
    localparam int DEF_CNT_BITS = 6;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2
    } state_t;
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction
endpackage

// File: rtl/binary_to_ascii_decimal_if.sv
// binary_to_ascii_decimal_if: request/result bundle between a number source and the converter
interface binary_to_ascii_decimal_if
    import binary_to_ascii_decimal_pkg::*;
#(
    parameter int BIN_BITS = DEF_BIN_BITS,
    parameter int BUF_BITS = DEF_BUF_BITS
);
    logic                start;
    logic [BIN_BITS-1:0] bin_in;
    logic                blank_zeros;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [BUF_BITS-1:0] ascii_out;
    modport master (
        output start, bin_in, blank_zeros,
        input  busy, done, overflow, ascii_out
    );
    modport slave (
        input  start, bin_in, blank_zeros,
        output busy, done, overflow, ascii_out
    );
endinterface

// File: rtl/binary_to_ascii_decimal_bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 to any digit of 5 or more
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/binary_to_ascii_decimal.sv
// binary_to_ascii_decimal: one-bit-per-clock double-dabble converter producing a packed ASCII buffer
module binary_to_ascii_decimal
    import binary_to_ascii_decimal_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int BITS_PER_ASCII_DIGIT = DEF_BITS_PER_ASCII_DIGIT,
    parameter int BIN_BITS = DEF_BIN_BITS,
    parameter int BUF_BITS = NUM_DIGITS * BITS_PER_ASCII_DIGIT,
    parameter int CNT_BITS = DEF_CNT_BITS
)(
    input logic clk,
    input logic reset_n,
    binary_to_ascii_decimal_if.slave bus
);
    localparam int BCD_BITS = 4 * NUM_DIGITS;
    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;
    state_t              state;
    logic [BIN_BITS-1:0] sh;
    logic [BCD_BITS-1:0] bcd;
    logic [BCD_BITS-1:0] bcd_adj;
    logic [CNT_BITS-1:0] cnt;
    logic                blank_q;
    logic                ovf_q;
    logic [BUF_BITS-1:0] fmt;
    logic                lead;
    logic [3:0]          nib;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (.d(bcd[4*i +: 4]), .q(bcd_adj[4*i +: 4]));
    end
    // Leading-zero blanking walks from the most significant digit; the last digit always prints.
    always_comb begin
        fmt = '0;
        lead = blank_q;
        nib = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib = bcd[4*k +: 4];
            fmt[BITS_PER_ASCII_DIGIT*k +: BITS_PER_ASCII_DIGIT] =
                (lead && nib == 4'd0 && k != 0) ? ASCII_SPACE : ASCII_ZERO + 8'(nib);
            lead = lead && nib == 4'd0;
        end
        if (ovf_q) fmt = {NUM_DIGITS{ASCII_DASH}};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            sh            <= '0;
            bcd           <= '0;
            cnt           <= '0;
            blank_q       <= 1'b0;
            ovf_q         <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.ascii_out <= {NUM_DIGITS{ASCII_SPACE}};
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: if (bus.start) begin
                    sh       <= bus.bin_in;
                    blank_q  <= bus.blank_zeros;
                    bcd      <= '0;
                    cnt      <= '0;
                    ovf_q    <= 64'(bus.bin_in) > MAX_VAL;
                    bus.busy <= 1'b1;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Carry out of the top nibble is dropped; ovf_q alone reports overflow.
                    bcd   <= (bcd_adj << 1) | {{(BCD_BITS-1){1'b0}}, sh[BIN_BITS-1]};
                    sh    <= sh << 1;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CNT_BITS'(BIN_BITS - 1)) ? ST_FORMAT : ST_SHIFT;
                end
                ST_FORMAT: begin
                    bus.ascii_out <= fmt;
                    bus.overflow  <= ovf_q;
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_binary_to_ascii_decimal.sv
// tb_binary_to_ascii_decimal: directed and random checks of the ASCII decimal converter
module tb_binary_to_ascii_decimal;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    binary_to_ascii_decimal_if bus ();
    binary_to_ascii_decimal dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] str80(input string s);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[79-8*i -: 8] = s[i];
        return r;
    endfunction

    // Reference: decimal digits by repeated division, then blank leading zeros except the last.
    function automatic logic [79:0] model(input logic [39:0] v, input bit b);
        logic [79:0]     r;
        longint unsigned x;
        bit              lead;
        x = 64'(v);
        lead = b;
        if (x > 64'd9999999999) return {10{8'h2D}};
        for (int k = 0; k < 10; k++) begin
            r[8*k +: 8] = 8'h30 + 8'(x % 10);
            x = x / 10;
        end
        for (int k = 9; k >= 1; k--) begin
            if (lead && r[8*k +: 8] == 8'h30) r[8*k +: 8] = 8'h20;
            else lead = 1'b0;
        end
        return r;
    endfunction

    task automatic conv(input logic [39:0] v, input bit b, input string tag);
        int lat;
        bit busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin_in = v;
        bus.blank_zeros = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.bin_in = 40'($urandom);
        bus.blank_zeros = ~b;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 80'(lat), 80'd41);
        check({tag, ".busy_during"}, 80'(busy_ok), 80'd1);
        check({tag, ".busy_at_done"}, 80'(bus.busy), 80'd0);
        check({tag, ".ascii"}, bus.ascii_out, model(v, b));
        check({tag, ".overflow"}, 80'(bus.overflow), 80'(64'(v) > 64'd9999999999));
        @(posedge clk);
        #1;
        check({tag, ".done_width"}, 80'(bus.done), 80'd0);
    endtask

    initial begin
        int              lat;
        int              ndone;
        longint unsigned x;
        longint unsigned lim;
        bus.start = 1'b0;
        bus.bin_in = '0;
        bus.blank_zeros = 1'b0;
        #12;
        check("reset.busy", 80'(bus.busy), 80'd0);
        check("reset.done", 80'(bus.done), 80'd0);
        check("reset.overflow", 80'(bus.overflow), 80'd0);
        check("reset.ascii", bus.ascii_out, {10{8'h20}});
        @(negedge clk);
        reset_n = 1'b1;

        conv(40'd0, 1'b1, "zero_blank");
        check("zero_blank.lit", bus.ascii_out, str80("         0"));
        conv(40'd9001, 1'b0, "9001");
        check("9001.lit", bus.ascii_out, str80("0000009001"));
        conv(40'd9001, 1'b1, "9001_blank");
        check("9001_blank.lit", bus.ascii_out, str80("      9001"));
        conv(40'd9999999999, 1'b0, "max");
        check("max.lit", bus.ascii_out, str80("9999999999"));
        conv(40'd10000000000, 1'b0, "ovf_min");
        check("ovf_min.lit", bus.ascii_out, str80("----------"));
        conv(40'hFF_FFFF_FFFF, 1'b1, "ovf_all1");
        check("ovf_all1.lit", bus.ascii_out, str80("----------"));
        conv(40'd0, 1'b0, "zero_noblank");
        check("overflow_clears", 80'(bus.overflow), 80'd0);

        // Second start while busy must be dropped.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin_in = 40'd9001;
        bus.blank_zeros = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin_in = 40'd10002;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 10;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("busy_start.latency", 80'(lat), 80'd41);
        check("busy_start.ascii", bus.ascii_out, str80("0000009001"));
        ndone = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("busy_start.no_second_done", 80'(ndone), 80'd0);

        // Asynchronous reset mid-conversion.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin_in = 40'd12345;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midreset.busy", 80'(bus.busy), 80'd0);
        check("midreset.done", 80'(bus.done), 80'd0);
        check("midreset.overflow", 80'(bus.overflow), 80'd0);
        check("midreset.ascii", bus.ascii_out, {10{8'h20}});
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("midreset.no_done", 80'(ndone), 80'd0);
        conv(40'd2000, 1'b0, "after_reset");
        check("after_reset.lit", bus.ascii_out, str80("0000002000"));

        for (int n = 0; n < 1000; n++) begin
            lim = 1;
            repeat ($urandom_range(0, 10)) lim = lim * 10;
            x = {$urandom, $urandom};
            conv(40'(x % lim), 1'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
